moving_avg_filter: RTL and testbench
====================================

// Module: moving_avg_filter
//
// PURPOSE
//  Multi-channel boxcar (moving-average) FIR for the audio path: out = mean of last 2^LOG2_TAPS samples per channel.
//  Sits between the CODEC sample source and the output/DAC side, with valid/ready handshake on both sides.
//  Keeps an exact full-width running sum, so no per-sample truncation error accumulates.
//  Output uses round-half-up division.
//  Adds a warm-up (primed) flag and a synchronous clear.
//
// PARAMETERS
//  DATA_W     24  signed sample width, per channel
//  CHANNELS   2   number of channels; all channels share one handshake and one frame
//  LOG2_TAPS  3   window length = 2^LOG2_TAPS; range 0..10; 0 = pass-through
//
// PORTS
//  clk        in   1                 clock
//  reset      in   1                 synchronous, active-high
//  clear      in   1                 synchronous flush of history; does not need reset
//  in_valid   in   1                 in_data frame valid
//  in_ready   out  1                 block accepts frame this cycle
//  in_data    in   CHANNELS*DATA_W   signed samples; ch k = bits [k*DATA_W +: DATA_W]
//  out_valid  out  1                 out_data holds an unconsumed result
//  out_ready  in   1                 consumer takes out_data this cycle
//  out_data   out  CHANNELS*DATA_W   averaged samples, same packing as in_data
//  primed     out  1                 window fully populated with real samples
//
// BEHAVIOUR
//  - Reset values: out_valid=0, out_data=0, primed=0; internally wr_ptr=0, fill_cnt=0, all acc=0.
//  - Handshake:
//      accept = in_valid & in_ready
//      in_ready = ~clear & (~out_valid | out_ready)
//    out_data is held stable while out_valid & ~out_ready.
//  - Per channel, on accept:
//      oldest = (fill_cnt == TAPS) ? hist[wr_ptr] : 0
//      acc <= acc + x - oldest
//      hist[wr_ptr] <= x
//    Then wr_ptr <= wr_ptr+1, wrapping mod TAPS.
//    fill_cnt saturates at TAPS, so the delay line needs no zero-initialisation.
//  - acc width = DATA_W + LOG2_TAPS, signed; all arithmetic is sign-extended. acc never overflows.
//  - Result = (acc_next + 2^(LOG2_TAPS-1)) >>> LOG2_TAPS, truncated to DATA_W.
//    This is provably in range, so no saturation is needed.
//    For LOG2_TAPS=0: result = x, with no rounding term.
//  - Latency: out_data/out_valid are registered and valid in the cycle after accept.
//    Sustained rate is 1 frame/clk when out_ready=1.
//  - out_valid: set on accept; else cleared when out_ready. Accept plus out_ready in the same cycle keeps it 1 with new data.
//  - primed: rises in the cycle out_valid presents the TAPS-th accepted frame; stays high until reset/clear.
//  - clear: acc, wr_ptr, fill_cnt, out_valid and primed go to 0 on the next edge; out_data keeps its value.
//    A frame presented with clear is not accepted (in_ready=0).
//  - reset mid-operation: identical to the reset values above. Any pending output is discarded.
//  - The hist RAM is never cleared; its stale contents are masked by fill_cnt.
//
// STRUCTURE
//  - Package moving_avg_pkg:
//      function acc_w(DATA_W, LOG2_TAPS)
//      function round_shift() (rounding + arithmetic shift)
//      typedef of the fill/ptr counter width helper
//  - Sub-module mavg_channel (DATA_W, LOG2_TAPS): per-channel history RAM, accumulator and rounding.
//    Inputs: accept, wr_ptr, full, clear. Generated CHANNELS times.
//  - Top level owns: wr_ptr, fill_cnt, handshake, output register, primed.
//
// TESTING  (DATA_W=24, CHANNELS=2, LOG2_TAPS=2, out_ready=1 unless stated)
//  1. reset, then ch0=400 for 6 frames:
//     -> out 100,200,300,400,400,400; primed high with the 4th output; ch1=0 -> out 0.
//  2. Rounding: ch1 = -3, -3 from zero history:
//     -> -1, -1 ((-3+2)>>>2, (-6+2)>>>2); ch0 = 2 -> 1 (0.5 rounds up).
//  3. Full scale: 4 frames of 0x7FFFFF -> 0x7FFFFF; then 4 frames of 0x800000 -> 0x800000.
//     No wrap at any step (check the intermediate value 0x000000 after frame 2).
//  4. Backpressure: hold out_ready=0 for 5 clks with in_valid=1:
//     -> in_ready=0, out_data stable; after release, the output sequence has no loss or duplicate.
//  5. clear asserted with in_valid=1 mid-stream:
//     -> frame dropped, out_valid=0 and primed=0 next clk; next frame x=800 -> out 200.
//  6. reset mid-window, then ch0=40:
//     -> out 10 (stale history ignored); random stream cross-checked against a reference model.

Source files
------------

// File: rtl/moving_avg_pkg.sv
// Shared sizing helpers and the rounding divider for the moving-average filter.
package moving_avg_pkg;

  // Largest supported window exponent (window of 1024 samples).
  localparam int MAX_LOG2_TAPS = 10;

  // Working width for the rounding helper; wide enough for any legal acc.
  localparam int RS_W = 64;

  // Fill counter must hold the value TAPS itself (up to 1024).
  typedef logic [MAX_LOG2_TAPS:0] fill_cnt_t;

  // Accumulator width: a sum of 2^log2_taps samples needs log2_taps extra bits.
  function automatic int acc_w(input int data_w, input int log2_taps);
    return data_w + log2_taps;
  endfunction

  // Write pointer width; a one-tap window still needs a 1-bit pointer.
  function automatic int ptr_w(input int log2_taps);
    return (log2_taps == 0) ? 1 : log2_taps;
  endfunction

  // Round-half-up divide by 2^sh: add half an LSB of the result, then shift
  // arithmetically. sh == 0 is a plain pass-through with no rounding term.
  function automatic logic signed [RS_W-1:0] round_shift(
    input logic signed [RS_W-1:0] v,
    input int                     sh
  );
    logic signed [RS_W-1:0] half;
    if (sh == 0) return v;
    half = {{(RS_W-1){1'b0}}, 1'b1} << (sh - 1);
    return (v + half) >>> sh;
  endfunction

endpackage

// File: rtl/mavg_channel.sv
// One channel of the boxcar: history RAM, exact running sum and rounded mean.
// The result output is combinational from the next accumulator value so the
// top level can register it in the same cycle the frame is accepted.
module mavg_channel
  import moving_avg_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int LOG2_TAPS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [ptr_w(LOG2_TAPS)-1:0]   wr_ptr,
  input  logic                          full,
  input  logic signed [DATA_W-1:0]      x,
  output logic signed [DATA_W-1:0]      result
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int ACC_W = acc_w(DATA_W, LOG2_TAPS);

  // Never cleared: entries not yet rewritten since reset/clear are masked by full.
  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  oldest;

  // Next running sum and its rounded mean; the slot at wr_ptr is the oldest sample.
  always_comb begin
    oldest   = full ? ACC_W'(hist[wr_ptr]) : '0;
    acc_next = acc + ACC_W'(x) - oldest;
    result   = DATA_W'(round_shift(RS_W'(acc_next), LOG2_TAPS));
  end

  // Delay line write: newest sample replaces the oldest.
  always_ff @(posedge clk) begin
    if (accept) hist[wr_ptr] <= x;
  end

  // Exact running sum; no truncation so no drift.
  always_ff @(posedge clk) begin
    if (reset || clear) acc <= '0;
    else if (accept)    acc <= acc_next;
  end

endmodule

// File: rtl/moving_avg_filter.sv
// Multi-channel moving-average filter with valid/ready on both sides.
// Handshake: a frame transfers on a rising edge where in_valid & in_ready;
// a result transfers where out_valid & out_ready. in_ready is held low during
// clear and whenever an unconsumed result would be overwritten, so out_data
// never changes while out_valid & ~out_ready.
module moving_avg_filter
  import moving_avg_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int CHANNELS  = 2,
  parameter int LOG2_TAPS = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         primed
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int PTR_W = ptr_w(LOG2_TAPS);

  logic [PTR_W-1:0]            wr_ptr;
  fill_cnt_t                   fill_cnt;
  logic                        full;
  logic                        accept;
  logic [CHANNELS*DATA_W-1:0]  result_bus;

  assign full     = (fill_cnt == fill_cnt_t'(TAPS));
  assign in_ready = ~clear & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    mavg_channel #(
      .DATA_W   (DATA_W),
      .LOG2_TAPS(LOG2_TAPS)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .accept(accept),
      .wr_ptr(wr_ptr),
      .full  (full),
      .x     (in_data[k*DATA_W +: DATA_W]),
      .result(result_bus[k*DATA_W +: DATA_W])
    );
  end

  // Shared write pointer and saturating fill count for all channels.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (accept) begin
      wr_ptr <= (LOG2_TAPS == 0) ? '0 : wr_ptr + 1'b1;
      if (!full) fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Output register, valid flag and warm-up flag; clear keeps out_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      primed    <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      primed    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result_bus;
      if (fill_cnt == fill_cnt_t'(TAPS - 1)) primed <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter with a 4-tap window on two channels.
module tb_moving_avg_filter;

  localparam int DW = 24;
  localparam int CH = 2;
  localparam int L2 = 2;
  localparam int W  = CH * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic          primed;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  bit           mon_en = 1'b0;

  // Clock / reset block
  always #5 clk = ~clk;

  moving_avg_filter #(
    .DATA_W   (DW),
    .CHANNELS (CH),
    .LOG2_TAPS(L2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .primed   (primed)
  );

  // Output monitor: record every consumed result
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) got_q.push_back(out_data);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] c0, input logic [DW-1:0] c1);
    bit   done = 1'b0;
    logic rdy;
    in_valid = 1'b1;
    in_data  = {c1, c0};
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    in_valid = 1'b0;
    n_assert++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_frame: got no accept, required accept within 50 clks");
    end
  endtask

  // Tests
  task automatic test_reset();
    do_reset();
    n_assert++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_assert++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    n_assert++;
    if (primed !== 1'b0) begin n_fail++; $display("FAIL reset_primed: got %b expected 0", primed); end
    n_assert++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_ramp();
    int e[6] = '{100, 200, 300, 400, 400, 400};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_frame(24'd400, 24'd0);
      n_assert++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ramp_valid[%0d]: got %b expected 1", i, out_valid); end
      n_assert++;
      if (out_data[DW-1:0] !== 24'(e[i])) begin n_fail++; $display("FAIL ramp_ch0[%0d]: got %0d expected %0d", i, out_data[DW-1:0], e[i]); end
      n_assert++;
      if (out_data[W-1:DW] !== 24'd0) begin n_fail++; $display("FAIL ramp_ch1[%0d]: got %0d expected 0", i, out_data[W-1:DW]); end
      n_assert++;
      if (primed !== (i >= 3)) begin n_fail++; $display("FAIL ramp_primed[%0d]: got %b expected %b", i, primed, (i >= 3)); end
    end
    step();
    n_assert++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ramp_drain_valid: got %b expected 0", out_valid); end
    n_assert++;
    if (primed !== 1'b1) begin n_fail++; $display("FAIL ramp_drain_primed: got %b expected 1", primed); end
  endtask

  task automatic test_rounding();
    do_reset();
    send_frame(24'd2, 24'hFFFFFD);
    n_assert++;
    if (out_data !== {24'hFFFFFF, 24'd1}) begin n_fail++; $display("FAIL round_f1: got %h expected %h", out_data, {24'hFFFFFF, 24'd1}); end
    send_frame(24'd0, 24'hFFFFFD);
    n_assert++;
    if (out_data !== {24'hFFFFFF, 24'd1}) begin n_fail++; $display("FAIL round_f2: got %h expected %h", out_data, {24'hFFFFFF, 24'd1}); end
  endtask

  task automatic test_full_scale();
    logic [DW-1:0] pos[4] = '{24'h200000, 24'h400000, 24'h5FFFFF, 24'h7FFFFF};
    logic [DW-1:0] neg[4] = '{24'h3FFFFF, 24'h000000, 24'hC00000, 24'h800000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(24'h7FFFFF, 24'h7FFFFF);
      n_assert++;
      if (out_data !== {pos[i], pos[i]}) begin n_fail++; $display("FAIL fs_pos[%0d]: got %h expected %h", i, out_data, {pos[i], pos[i]}); end
    end
    for (int i = 0; i < 4; i++) begin
      send_frame(24'h800000, 24'h800000);
      n_assert++;
      if (out_data !== {neg[i], neg[i]}) begin n_fail++; $display("FAIL fs_neg[%0d]: got %h expected %h", i, out_data, {neg[i], neg[i]}); end
    end
  endtask

  task automatic test_back_to_back();
    int e[5] = '{1, 3, 6, 10, 14};
    do_reset();
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({24'(-e[i]), 24'(e[i])});
    mon_en    = 1'b1;
    out_ready = 1'b1;
    send_frame(24'd4, 24'(-4));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {24'(-8), 24'd8};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_assert++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
      n_assert++;
      if (out_valid !== 1'b1 || out_data !== {24'(-1), 24'd1}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, {24'(-1), 24'd1});
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      in_data  = {24'(-4 * (i + 1)), 24'(4 * (i + 1))};
      in_valid = 1'b1;
      @(negedge clk);
      n_assert++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    step();
    step();
    mon_en = 1'b0;
    n_assert++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d results expected %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_assert++;
        if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(24'd400, 24'd0);
    n_assert++;
    if (primed !== 1'b1) begin n_fail++; $display("FAIL clr_pre_primed: got %b expected 1", primed); end
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = {24'd0, 24'd999};
    @(negedge clk);
    n_assert++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clr_in_ready: got %b expected 0", in_ready); end
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    n_assert++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_out_valid: got %b expected 0", out_valid); end
    n_assert++;
    if (primed !== 1'b0) begin n_fail++; $display("FAIL clr_primed: got %b expected 0", primed); end
    n_assert++;
    if (out_data !== {24'd0, 24'd400}) begin n_fail++; $display("FAIL clr_data_kept: got %h expected %h", out_data, {24'd0, 24'd400}); end
    send_frame(24'd800, 24'd0);
    n_assert++;
    if (out_data !== {24'd0, 24'd200}) begin n_fail++; $display("FAIL clr_next: got %h expected %h", out_data, {24'd0, 24'd200}); end
    n_assert++;
    if (primed !== 1'b0) begin n_fail++; $display("FAIL clr_next_primed: got %b expected 0", primed); end
  endtask

  task automatic test_reset_mid_and_random();
    longint        w0[$];
    longint        w1[$];
    longint        s0;
    longint        s1;
    logic [DW-1:0] r0;
    logic [DW-1:0] r1;
    logic [W-1:0]  expv;
    do_reset();
    send_frame(24'd1000, 24'd1000);
    send_frame(24'd1000, 24'd1000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_assert++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b data=%h expected valid=0 data=0", out_valid, out_data);
    end
    send_frame(24'd40, 24'd0);
    n_assert++;
    if (out_data !== {24'd0, 24'd10}) begin n_fail++; $display("FAIL mid_reset_first: got %h expected %h", out_data, {24'd0, 24'd10}); end
    w0.push_back(40);
    w1.push_back(0);
    for (int i = 0; i < 30; i++) begin
      r0 = 24'($urandom);
      r1 = 24'($urandom_range(0, 2000)) - 24'd1000;
      w0.push_back(longint'($signed(r0)));
      w1.push_back(longint'($signed(r1)));
      if (w0.size() > 4) void'(w0.pop_front());
      if (w1.size() > 4) void'(w1.pop_front());
      s0 = 0;
      s1 = 0;
      foreach (w0[j]) s0 += w0[j];
      foreach (w1[j]) s1 += w1[j];
      expv = {24'((s1 + 2) >>> 2), 24'((s0 + 2) >>> 2)};
      send_frame(r0, r1);
      n_assert++;
      if (out_data !== expv) begin n_fail++; $display("FAIL rand[%0d]: got %h expected %h", i, out_data, expv); end
    end
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_ramp();
    test_rounding();
    test_full_scale();
    test_back_to_back();
    test_clear();
    test_reset_mid_and_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
